seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised multi-cycle ALU. Replaces the fixed-width, purely combinational datapath with a start/done engine. Single-cycle ops complete in one clock. MUL uses an iterative shift-add engine, and DIV/MOD use a restoring-division engine. It sits between the operand/opcode registers and the persistent result register, and keeps the existing 4-bit opcode map, adding MOD and a real CLEAR.

## Interface
- WIDTH, 16, operand/result width; power of two, ≥4
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high; clock clk
- start  in  1  request; accepted only when busy=0
- opcode  in  4  operation, sampled on accept
- a, b  in  WIDTH  operands, sampled on accept
- busy  out  1  high from cycle after accept until done cycle inclusive
- done  out  1  one-cycle pulse; result/error valid this cycle and held after
- result  out  WIDTH  registered result
- error  out  1  registered error flag, meaning per opcode

## Operation
- Opcodes:
  - 0 AND, 1 NOT a, 2 NOT b, 3 OR, 4 NOR, 5 NAND, 6 XOR, 7 XNOR
  - 8 ADD, 9 MUL, 10 DIV, 11 NOOP, 12 SRL, 13 SLL, 14 MOD, 15 CLEAR
- All arithmetic unsigned.
- Per-op result and error:
  - ADD: result = (a+b) mod 2^WIDTH; error = carry-out.
  - MUL: result = low WIDTH bits of a*b; error = 1 if any high bit is nonzero.
  - DIV/MOD: result = a/b or a%b; error=0.
  - DIV/MOD with b=0: error=1; DIV result = all-ones; MOD result = a; no iteration.
  - SRL/SLL: logical shift of a by b[SHW-1:0]; upper b bits ignored; error=0.
  - Logic ops: error=0.
  - NOOP: result and error unchanged; done still pulses.
  - CLEAR: result=0, error=0.
- FSM states:
  - IDLE: start → ONE for ops 0–8, 11–13, 15, and for DIV/MOD with b=0; start → ITER for MUL, and for DIV/MOD with b≠0.
  - ONE: writes result → DONE.
  - ITER: one bit per cycle, WIDTH iterations; counter reaches WIDTH-1 → DONE.
  - DONE: done=1 → IDLE.
- MUL engine: 2·WIDTH product accumulator; multiplier shifted right one bit per cycle.
- DIV engine: WIDTH+1-bit partial remainder; one restore/subtract step per cycle, MSB first.
- start while busy=1 is ignored; no queueing; the operation in flight is not disturbed.
- Operand/opcode inputs may change freely after the accept cycle.

## Timing
- Reset values: busy=0, done=0, result=0, error=0, state IDLE, counter 0.
- Accept edge = the rising clk edge where start=1 and busy=0.
- Single-cycle ops: done=1 in the 2nd cycle after accept (latency 2 edges).
- MUL/DIV/MOD: done=1 exactly WIDTH+2 edges after accept (18 for WIDTH=16).
- Back-to-back: start may be asserted during the done cycle. busy=1 then, so that start is ignored; the next accept is the cycle after done.
- result/error update only on the edge that raises done; otherwise they are stable.
- Reset asserted mid-ITER: aborts immediately (asynchronously), all outputs return to reset values, no done pulse.

## Structure
- seq_alu_pkg holds:
  - opcode localparams: OP_AND … OP_CLEAR
  - state enum: IDLE, ONE, ITER, DONE
  - helper function for the combinational single-cycle op results
- One sub-module, seq_muldiv_unit (WIDTH parameter):
  - inputs: load, is_div, a, b
  - outputs: result_lo, overflow, quotient, remainder, last
  - owns the iteration counter and shift registers
- Top level owns the FSM, operand latches, one-cycle op mux, and output registers.

## Test plan
- WIDTH=16, DIV a=40000 b=5 → done 18 edges after accept, result=8000, error=0; MOD a=40000 b=7 → result=2.
- MUL a=200 b=1000 → result=3392, error=1; MUL a=255 b=255 → result=65025, error=0.
- SRL a=32 b=5 → result=1; SLL a=2 b=4 → result=32; SLL a=1 b=16'h0013 → result=8 (upper b bits ignored).
- DIV a=123 b=0 → done 2 edges after accept, result=16'hFFFF, error=1; MOD a=123 b=0 → result=123, error=1.
- ADD 0xFFFF+1 → result=0, error=1; then NOOP → result=0, error=1 held, done pulses; CLEAR → result=0, error=0.
- Two starts during a MUL:
  - Second start (different operands) during busy → ignored; first result correct.
  - Reset asserted at iteration 5 → outputs 0, no done.
- Repeat the DIV and MUL checks at WIDTH=8 (latency 10 edges).

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state type and single-cycle helpers for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_NOTA  = 4'd1;
  localparam logic [3:0] OP_NOTB  = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_NOR   = 4'd4;
  localparam logic [3:0] OP_NAND  = 4'd5;
  localparam logic [3:0] OP_XOR   = 4'd6;
  localparam logic [3:0] OP_XNOR  = 4'd7;
  localparam logic [3:0] OP_ADD   = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_NOOP  = 4'd11;
  localparam logic [3:0] OP_SRL   = 4'd12;
  localparam logic [3:0] OP_SLL   = 4'd13;
  localparam logic [3:0] OP_MOD   = 4'd14;
  localparam logic [3:0] OP_CLEAR = 4'd15;

  typedef enum logic [1:0] {IDLE, ONE, ITER, DONE} state_t;

  // Per-bit result of the eight bitwise opcodes (low three opcode bits).
  function automatic logic f_logic_bit(input logic [2:0] op, input logic a, input logic b);
    logic r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = ~a;
      3'd2:    r = ~b;
      3'd3:    r = a | b;
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a & b);
      3'd6:    r = a ^ b;
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  // Division by zero short-circuits to the single-cycle path.
  function automatic logic f_is_iter(input logic [3:0] op, input logic b_zero);
    return (op == OP_MUL) || (((op == OP_DIV) || (op == OP_MOD)) && !b_zero);
  endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative engine: shift-add multiplier and restoring divider, one bit per clock.
module seq_muldiv_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result_lo,
  output logic             o_overflow,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_last
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [CW-1:0]        r_cnt;
  logic                 r_run;
  logic                 r_last;
  logic                 r_div_mode;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dvsr;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;

  // Partial remainder widened by one bit as the next dividend bit shifts in.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_dvsr};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_run      <= 1'b0;
      r_last     <= 1'b0;
      r_div_mode <= 1'b0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
    end else if (i_load) begin
      r_cnt      <= '0;
      r_run      <= 1'b1;
      r_last     <= 1'b0;
      r_div_mode <= i_is_div;
      r_acc      <= '0;
      r_mcand    <= {{WIDTH{1'b0}}, i_a};
      r_mplier   <= i_b;
      r_rem      <= '0;
      r_quo      <= i_a;
      r_dvsr     <= i_b;
    end else if (r_run) begin
      if (r_div_mode) begin
        r_rem <= w_ge ? WIDTH'(w_shift - {1'b0, r_dvsr}) : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
      end else begin
        r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (r_cnt == CNT_LAST) begin
        r_run  <= 1'b0;
        r_last <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_result_lo = r_acc[WIDTH-1:0];
  assign o_overflow  = |r_acc[2*WIDTH-1:WIDTH];
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_last      = r_last;

endmodule

// File: rtl/seq_alu.sv
// Start/done ALU: single-cycle ops via ONE, MUL/DIV/MOD via the iterative engine.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_opcode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_error
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_op;

  logic             w_load;
  logic             w_is_div;
  logic [WIDTH-1:0] w_mul_lo;
  logic             w_mul_ovf;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_last;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_one_res;
  logic             w_one_err;

  // The engine loads straight from the inputs on the accept edge.
  assign w_is_div = (i_opcode == OP_DIV) || (i_opcode == OP_MOD);
  assign w_load   = (r_state == IDLE) && i_start && f_is_iter(i_opcode, i_b == '0);

  seq_muldiv_unit #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_is_div   (w_is_div),
    .i_a        (i_a),
    .i_b        (i_b),
    .o_result_lo(w_mul_lo),
    .o_overflow (w_mul_ovf),
    .o_quotient (w_quo),
    .o_remainder(w_rem),
    .o_last     (w_last)
  );

  assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, r_b};
  assign w_sh             = r_b[SHW-1:0];

  always_comb begin
    w_logic = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_logic[i] = f_logic_bit(r_op[2:0], r_a[i], r_b[i]);
    end
  end

  always_comb begin
    w_one_res = '0;
    w_one_err = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_one_res = w_sum;
        w_one_err = w_carry;
      end
      OP_SRL: w_one_res = r_a >> w_sh;
      OP_SLL: w_one_res = r_a << w_sh;
      OP_DIV: begin
        w_one_res = '1;
        w_one_err = 1'b1;
      end
      OP_MOD: begin
        w_one_res = r_a;
        w_one_err = 1'b1;
      end
      OP_MUL, OP_NOOP, OP_CLEAR: w_one_res = '0;
      default: w_one_res = w_logic;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_AND;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_op    <= i_opcode;
            r_a     <= i_a;
            r_b     <= i_b;
            r_busy  <= 1'b1;
            r_state <= w_load ? ITER : ONE;
          end
        end
        ONE: begin
          if (r_op != OP_NOOP) begin
            r_result <= w_one_res;
            r_error  <= w_one_err;
          end
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        ITER: begin
          if (w_last) begin
            if (r_op == OP_MUL) begin
              r_result <= w_mul_lo;
              r_error  <= w_mul_ovf;
            end else begin
              r_result <= (r_op == OP_DIV) ? w_quo : w_rem;
              r_error  <= 1'b0;
            end
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_error  = r_error;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=16 and WIDTH=8.
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] res;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s16_start = 1'b0;
  logic [3:0]  s16_op = 4'd0;
  logic [15:0] s16_a = '0;
  logic [15:0] s16_b = '0;
  logic        d16_busy, d16_done, d16_err;
  logic [15:0] d16_res;
  logic        s8_start = 1'b0;
  logic [3:0]  s8_op = 4'd0;
  logic [7:0]  s8_a = '0;
  logic [7:0]  s8_b = '0;
  logic        d8_busy, d8_done, d8_err;
  logic [7:0]  d8_res;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  seq_alu #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_reset(reset), .i_start(s16_start), .i_opcode(s16_op), .i_a(s16_a),
    .i_b(s16_b), .o_busy(d16_busy), .o_done(d16_done), .o_result(d16_res), .o_error(d16_err)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_reset(reset), .i_start(s8_start), .i_opcode(s8_op), .i_a(s8_a),
    .i_b(s8_b), .o_busy(d8_busy), .o_done(d8_done), .o_result(d8_res), .o_error(d8_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (d16_done) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w16_spurious_done: got done result=%0h expected no done", d16_res);
      end else begin
        e16 = q16.pop_front();
        chk($sformatf("w16_op%0d_result", e16.op), {16'd0, d16_res}, {16'd0, e16.res});
        chk($sformatf("w16_op%0d_error", e16.op), {31'd0, d16_err}, {31'd0, e16.err});
        chk($sformatf("w16_op%0d_latency", e16.op), cyc - e16.acc, e16.lat);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (d8_done) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w8_spurious_done: got done result=%0h expected no done", d8_res);
      end else begin
        e8 = q8.pop_front();
        chk($sformatf("w8_op%0d_result", e8.op), {24'd0, d8_res}, {16'd0, e8.res});
        chk($sformatf("w8_op%0d_error", e8.op), {31'd0, d8_err}, {31'd0, e8.err});
        chk($sformatf("w8_op%0d_latency", e8.op), cyc - e8.acc, e8.lat);
      end
    end
  end

  task automatic issue(input bit w8, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] er, input logic ee,
                       input int lat, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while ((w8 ? d8_busy : d16_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (w8 ? d8_busy : d16_busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got busy=1 expected idle before op %0d", op);
    end else begin
      e.op = op; e.res = er; e.err = ee; e.lat = lat; e.acc = cyc;
      if (w8) begin
        s8_start = 1'b1; s8_op = op; s8_a = a[7:0]; s8_b = b[7:0];
        if (push) q8.push_back(e);
      end else begin
        s16_start = 1'b1; s16_op = op; s16_a = a; s16_b = b;
        if (push) q16.push_back(e);
      end
      @(negedge clk);
      // Scramble operands after accept; the DUT must have latched them.
      s8_start = 1'b0; s8_a = ~s8_a; s8_b = ~s8_b; s8_op = ~s8_op;
      s16_start = 1'b0; s16_a = ~s16_a; s16_b = ~s16_b; s16_op = ~s16_op;
      chk(w8 ? "w8_busy_after_accept" : "w16_busy_after_accept",
          {31'd0, (w8 ? d8_busy : d16_busy)}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q16.size() != 0 || q8.size() != 0 || d16_busy || d8_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q16.size() + q8.size());
    end
  endtask

  initial begin
    int n;
    #23 reset = 1'b0;
    @(negedge clk);
    chk("w16_reset_busy", {31'd0, d16_busy}, 32'd0);
    chk("w16_reset_done", {31'd0, d16_done}, 32'd0);
    chk("w16_reset_result", {16'd0, d16_res}, 32'd0);
    chk("w16_reset_error", {31'd0, d16_err}, 32'd0);
    chk("w8_reset_busy", {31'd0, d8_busy}, 32'd0);
    chk("w8_reset_done", {31'd0, d8_done}, 32'd0);
    chk("w8_reset_result", {24'd0, d8_res}, 32'd0);
    chk("w8_reset_error", {31'd0, d8_err}, 32'd0);

    issue(0, OP_DIV,  16'd40000, 16'd5,    16'd8000,  1'b0, 18, 1);
    issue(0, OP_MOD,  16'd40000, 16'd7,    16'd2,     1'b0, 18, 1);
    issue(0, OP_MUL,  16'd200,   16'd1000, 16'd3392,  1'b1, 18, 1);
    issue(0, OP_MUL,  16'd255,   16'd255,  16'd65025, 1'b0, 18, 1);
    issue(0, OP_DIV,  16'hFFFF,  16'd1,    16'hFFFF,  1'b0, 18, 1);
    issue(0, OP_MOD,  16'd7,     16'd9,    16'd7,     1'b0, 18, 1);
    issue(0, OP_SRL,  16'd32,    16'd5,    16'd1,     1'b0, 2,  1);
    issue(0, OP_SLL,  16'd2,     16'd4,    16'd32,    1'b0, 2,  1);
    issue(0, OP_SLL,  16'd1,     16'h0013, 16'd8,     1'b0, 2,  1);
    issue(0, OP_DIV,  16'd123,   16'd0,    16'hFFFF,  1'b1, 2,  1);
    issue(0, OP_MOD,  16'd123,   16'd0,    16'd123,   1'b1, 2,  1);
    issue(0, OP_ADD,  16'hFFFF,  16'd1,    16'd0,     1'b1, 2,  1);
    issue(0, OP_NOOP, 16'h1234,  16'h5678, 16'd0,     1'b1, 2,  1);
    issue(0, OP_CLEAR,16'h1234,  16'h5678, 16'd0,     1'b0, 2,  1);
    issue(0, OP_ADD,  16'd5,     16'd6,    16'd11,    1'b0, 2,  1);
    issue(0, OP_NOOP, 16'hFFFF,  16'hFFFF, 16'd11,    1'b0, 2,  1);
    issue(0, OP_AND,  16'hF0F0,  16'hFF00, 16'hF000,  1'b0, 2,  1);
    issue(0, OP_NOTA, 16'h00FF,  16'h0000, 16'hFF00,  1'b0, 2,  1);
    issue(0, OP_NOTB, 16'h0000,  16'h1234, 16'hEDCB,  1'b0, 2,  1);
    issue(0, OP_NOR,  16'hF0F0,  16'hFF00, 16'h000F,  1'b0, 2,  1);
    issue(0, OP_NAND, 16'hF0F0,  16'hFF00, 16'h0FFF,  1'b0, 2,  1);
    issue(0, OP_XNOR, 16'hF0F0,  16'hFF00, 16'hF00F,  1'b0, 2,  1);

    // Starts while busy, including during the done cycle, must be dropped.
    issue(0, OP_MUL, 16'd200, 16'd1000, 16'd3392, 1'b1, 18, 1);
    repeat (3) @(negedge clk);
    s16_start = 1'b1; s16_op = OP_ADD; s16_a = 16'd7; s16_b = 16'd9;
    repeat (2) @(negedge clk);
    s16_start = 1'b0;
    n = 0;
    while (!d16_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w16_done_seen_for_busy_test", {31'd0, d16_done}, 32'd1);
    s16_start = 1'b1;
    @(negedge clk);
    s16_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("w16_ignored_start_not_accepted", {31'd0, d16_busy}, 32'd0);

    // Reset during iteration 5 of a MUL: outputs clear immediately, no done.
    issue(0, OP_MUL, 16'd3, 16'd4, 16'd12, 1'b0, 18, 0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("w16_abort_busy", {31'd0, d16_busy}, 32'd0);
    chk("w16_abort_done", {31'd0, d16_done}, 32'd0);
    chk("w16_abort_result", {16'd0, d16_res}, 32'd0);
    chk("w16_abort_error", {31'd0, d16_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    chk("w16_abort_result_held", {16'd0, d16_res}, 32'd0);

    issue(1, OP_DIV, 16'd200, 16'd7,  16'd28,  1'b0, 10, 1);
    issue(1, OP_MOD, 16'd200, 16'd7,  16'd4,   1'b0, 10, 1);
    issue(1, OP_MUL, 16'd20,  16'd13, 16'd4,   1'b1, 10, 1);
    issue(1, OP_MUL, 16'd15,  16'd17, 16'd255, 1'b0, 10, 1);
    issue(1, OP_DIV, 16'd50,  16'd0,  16'hFF,  1'b1, 2,  1);

    wait_idle();
    chk("queues_drained", q16.size() + q8.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
